// File: rtl/uart_rx_sampler_pkg.sv
// Shared definitions for the UART receive path: state encoding, frame
// geometry and the clocks-per-bit helper (also intended for the TX block).
package uart_rx_sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = 4;

  // Clocks per bit; callers must keep the result >= 4 so the half-bit
  // compare and the full-bit compare land on distinct counter values.
  function automatic int calc_cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_baud_timer.sv
// Bit-period timer: tick after every full bit period, half_tick once half a
// bit has elapsed since the last clear.
module uart_baud_timer #(
  parameter int CPB = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick,
  output logic half_tick
);

  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] LOAD = CW'(CPB - 1);
  // Down-counter: elapsed clocks since clear = (CPB-1) - cnt, so the
  // half-bit point (elapsed CPB/2-1) sits at cnt = CPB - CPB/2.
  localparam logic [CW-1:0] HALF = CW'(CPB - CPB / 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= LOAD;
    end else if (cnt == '0) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick      = (cnt == '0);
  assign half_tick = (cnt == HALF);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: validates the start bit at mid-bit, shifts in eight
// data bits LSB first, checks the stop bit and reports the byte or an error.
//
// state | meaning
// IDLE  | waiting for start_bit (must be seen high on two IDLE cycles)
// START | half-bit wait, then re-check the start bit
// DATA  | sample one data bit per bit period
// STOP  | sample the stop bit, publish byte or flag framing error
// DONE  | one-cycle settle after a complete frame
// ABORT | one-cycle false-start exit, bit_cnt forced to 8
module uart_rx_sampler
  import uart_rx_sampler_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_bit,
  input  logic                 data,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic [7:0]           rx_byte,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CPB = calc_cpb(CLK_HZ, BAUD);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] ALL_BITS = BIT_CNT_W'(DATA_BITS);

  state_t     state, state_next;
  logic       rx_meta, rxs;
  logic       start_q;
  logic [7:0] sh;
  logic       tick, half_tick, clr;
  logic       stop_good, stop_bad;

  uart_baud_timer #(.CPB(CPB)) u_baud_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .tick      (tick),
    .half_tick (half_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= data;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      ST_IDLE:  if (start_bit && start_q) state_next = ST_START;
      ST_START: if (half_tick) state_next = rxs ? ST_ABORT : ST_DATA;
      ST_DATA:  if (tick && (bit_cnt == LAST_BIT)) state_next = ST_STOP;
      ST_STOP: begin
        if (tick) begin
          state_next = ST_DONE;
          stop_good  = rxs;
          stop_bad   = ~rxs;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Restart the bit timer on every state change so each phase is timed
  // from its own entry.
  assign clr  = (state_next != state);
  assign busy = (state != ST_IDLE);

  // start_q only remembers start_bit seen while idle, so a level still high
  // from the previous frame cannot re-arm on the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= (state == ST_IDLE) && start_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
    end else if ((state == ST_DATA) && tick) begin
      sh <= {rxs, sh[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if ((state_next == ST_IDLE) && (state != ST_IDLE)) begin
      bit_cnt <= '0;
    end else if (state_next == ST_ABORT) begin
      bit_cnt <= ALL_BITS;
    end else if ((state == ST_DATA) && tick) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= stop_good;
      frame_err <= stop_bad;
      if (stop_good) begin
        rx_byte <= sh;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler at CPB=16 with a start-detector model and a
// frame-level reference model of expected bytes and errors.
module tb_uart_rx_sampler;

  localparam int CLK_HZ  = 160;
  localparam int BAUD    = 10;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int EXP_LAT = CPB / 2 + 9 * CPB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_bit = 1'b0;
  logic       data = 1'b1;
  logic [3:0] bit_cnt;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;

  typedef struct {
    logic       good;
    logic [7:0] b;
    int         t;
  } ev_t;

  ev_t  mon_q[$];
  int   overlap_cnt = 0;
  int   wide_cnt = 0;
  int   bcnt_max = 0;
  logic rv_d = 1'b0, fe_d = 1'b0;
  logic det_prev = 1'b1;
  logic [7:0] exp_rx_byte = 8'h00;

  always #5 clk = ~clk;

  uart_rx_sampler #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_bit (start_bit),
    .data      (data),
    .bit_cnt   (bit_cnt),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Start-edge detector model: raise on a falling line edge, release at bit_cnt==8.
  always @(posedge clk) begin
    if (reset) begin
      start_bit <= 1'b0;
      det_prev  <= 1'b1;
    end else begin
      det_prev <= data;
      if (bit_cnt == 4'd8) start_bit <= 1'b0;
      else if (det_prev && !data) start_bit <= 1'b1;
    end
  end

  always @(negedge clk) begin
    rv_d <= rx_valid;
    fe_d <= frame_err;
    if (rx_valid && frame_err) overlap_cnt <= overlap_cnt + 1;
    if ((rx_valid && rv_d) || (frame_err && fe_d)) wide_cnt <= wide_cnt + 1;
    if (int'(bit_cnt) > bcnt_max) bcnt_max <= int'(bit_cnt);
    if (rx_valid) mon_q.push_back('{1'b1, rx_byte, cyc});
    if (frame_err) mon_q.push_back('{1'b0, 8'h00, cyc});
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    mon_q.delete();
    overlap_cnt = 0;
    wide_cnt = 0;
    bcnt_max = 0;
    @(negedge clk);
  endtask

  // Drive one frame; every interior line edge moves by up to +/-skew clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int skew);
    int off[11];
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    off[0] = 0;
    off[10] = 0;
    for (int i = 1; i < 10; i++)
      off[i] = (skew == 0) ? 0 : int'($urandom_range(2 * skew, 0)) - skew;
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      data = bits[i];
      repeat (CPB + off[i+1] - off[i]) @(negedge clk);
    end
    data = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bit_cnt !== 4'd0) begin failures++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    checks++; if (rx_byte !== 8'h00) begin failures++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
    checks++; if ({rx_valid, frame_err} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b want 00", {rx_valid, frame_err}); end
    reset = 1'b0;
    wait_cycles(5);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_good_frame();
    clear_mon();
    send_frame(8'hA5, 1'b1, 0);
    exp_rx_byte = 8'hA5;
    wait_cycles(20);
    checks++; if (mon_q.size() !== 1) begin failures++; $display("FAIL a5_events: got %0d want 1", mon_q.size()); end
    if (mon_q.size() > 0) begin
      checks++; if (mon_q[0].good !== 1'b1 || mon_q[0].b !== 8'hA5) begin failures++; $display("FAIL a5_byte: got good=%b byte=%h want good=1 byte=a5", mon_q[0].good, mon_q[0].b); end
      checks++; if ((mon_q[0].t - t_start) < EXP_LAT - 2 || (mon_q[0].t - t_start) > EXP_LAT + 2) begin failures++; $display("FAIL a5_latency: got %0d want %0d+/-2", mon_q[0].t - t_start, EXP_LAT); end
    end
    checks++; if (rx_byte !== 8'hA5) begin failures++; $display("FAIL a5_rx_byte: got %h want a5", rx_byte); end
    checks++; if (bcnt_max !== 8) begin failures++; $display("FAIL a5_bit_cnt_max: got %0d want 8", bcnt_max); end
    checks++; if (start_bit !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL a5_release: got start_bit=%b busy=%b want 0 0", start_bit, busy); end
    checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL a5_pulse_width: got %0d wide pulses want 0", wide_cnt); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h3C, 1'b0, 0);
    wait_cycles(20);
    checks++; if (mon_q.size() !== 1) begin failures++; $display("FAIL ferr_events: got %0d want 1", mon_q.size()); end
    if (mon_q.size() > 0) begin
      checks++; if (mon_q[0].good !== 1'b0) begin failures++; $display("FAIL ferr_kind: got rx_valid want frame_err"); end
    end
    checks++; if (rx_byte !== exp_rx_byte) begin failures++; $display("FAIL ferr_rx_byte_held: got %h want %h", rx_byte, exp_rx_byte); end
    checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL ferr_overlap: got %0d want 0", overlap_cnt); end
  endtask

  task automatic test_glitch();
    int n8;
    logic saw_busy;
    clear_mon();
    n8 = 0;
    saw_busy = 1'b0;
    data = 1'b0;
    wait_cycles(3);
    data = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bit_cnt == 4'd8) n8++;
      if (busy) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_armed: got busy never high want high"); end
    checks++; if (n8 !== 1) begin failures++; $display("FAIL glitch_bit_cnt8: got %0d cycles want 1", n8); end
    checks++; if (mon_q.size() !== 0) begin failures++; $display("FAIL glitch_pulses: got %0d events want 0", mon_q.size()); end
    checks++; if (busy !== 1'b0 || start_bit !== 1'b0) begin failures++; $display("FAIL glitch_idle: got busy=%b start_bit=%b want 0 0", busy, start_bit); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    exp_rx_byte = 8'hFF;
    wait_cycles(20);
    checks++; if (mon_q.size() !== 2) begin failures++; $display("FAIL b2b_events: got %0d want 2", mon_q.size()); end
    if (mon_q.size() == 2) begin
      checks++; if (!mon_q[0].good || mon_q[0].b !== 8'h00) begin failures++; $display("FAIL b2b_first: got good=%b byte=%h want 1 00", mon_q[0].good, mon_q[0].b); end
      checks++; if (!mon_q[1].good || mon_q[1].b !== 8'hFF) begin failures++; $display("FAIL b2b_second: got good=%b byte=%h want 1 ff", mon_q[1].good, mon_q[1].b); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] partial;
    partial = 8'hC3;
    clear_mon();
    data = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      data = partial[i];
      wait_cycles(CPB);
    end
    data = partial[4];
    wait_cycles(CPB / 2);
    checks++; if (bit_cnt !== 4'd4 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre_reset: got bit_cnt=%0d busy=%b want 4 1", bit_cnt, busy); end
    reset = 1'b1;
    @(negedge clk);
    exp_rx_byte = 8'h00;
    checks++; if ({busy, rx_valid, frame_err} !== 3'b000 || bit_cnt !== 4'd0 || rx_byte !== 8'h00) begin
      failures++; $display("FAIL mid_reset_outputs: got busy=%b rv=%b fe=%b bit_cnt=%0d byte=%h want all 0", busy, rx_valid, frame_err, bit_cnt, rx_byte);
    end
    data = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(20);
    send_frame(8'h5A, 1'b1, 0);
    exp_rx_byte = 8'h5A;
    wait_cycles(20);
    checks++; if (mon_q.size() !== 1) begin failures++; $display("FAIL mid_events: got %0d want 1", mon_q.size()); end
    checks++; if (rx_byte !== 8'h5A) begin failures++; $display("FAIL mid_5a: got %h want 5a", rx_byte); end
  endtask

  task automatic test_skew();
    for (int r = 0; r < 4; r++) begin
      clear_mon();
      send_frame(8'h81, 1'b1, 3);
      exp_rx_byte = 8'h81;
      wait_cycles(20);
      checks++;
      if (mon_q.size() !== 1 || rx_byte !== 8'h81) begin
        failures++; $display("FAIL skew_81_run%0d: got events=%0d byte=%h want 1 81", r, mon_q.size(), rx_byte);
      end
    end
  endtask

  task automatic test_random();
    ev_t exp_q[$];
    logic [7:0] b;
    logic stop;
    clear_mon();
    for (int f = 0; f < 8; f++) begin
      b = 8'($urandom);
      stop = ($urandom_range(3, 0) != 0);
      send_frame(b, stop, int'($urandom_range(3, 0)));
      if (stop) begin
        exp_q.push_back('{1'b1, b, 0});
        exp_rx_byte = b;
        wait_cycles(int'($urandom_range(15, 0)));
      end else begin
        exp_q.push_back('{1'b0, 8'h00, 0});
        wait_cycles(int'($urandom_range(15, 2)));
      end
    end
    wait_cycles(20);
    checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_events: got %0d want %0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].good !== exp_q[i].good || mon_q[i].b !== exp_q[i].b) begin
        failures++; $display("FAIL rand_frame%0d: got good=%b byte=%h want good=%b byte=%h", i, mon_q[i].good, mon_q[i].b, exp_q[i].good, exp_q[i].b);
      end
    end
    checks++; if (rx_byte !== exp_rx_byte) begin failures++; $display("FAIL rand_rx_byte: got %h want %h", rx_byte, exp_rx_byte); end
    checks++; if (overlap_cnt !== 0 || wide_cnt !== 0) begin failures++; $display("FAIL rand_pulse_shape: got overlap=%0d wide=%0d want 0 0", overlap_cnt, wide_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_skew();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
